// File: rtl/user_proj_bram_wb_if.sv
// Wishbone classic slave bus bundle for the user-project memory.
// Signal names keep the Caravel wbs_* naming so the top level reads like
// the rest of the user project wrapper.
interface user_proj_bram_wb_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_cyc_i,
        input  wbs_stb_i,
        input  wbs_we_i,
        input  wbs_sel_i,
        input  wbs_adr_i,
        input  wbs_dat_i,
        output wbs_ack_o,
        output wbs_dat_o
    );

    modport master (
        output wbs_cyc_i,
        output wbs_stb_i,
        output wbs_we_i,
        output wbs_sel_i,
        output wbs_adr_i,
        output wbs_dat_i,
        input  wbs_ack_o,
        input  wbs_dat_o
    );
endinterface

// File: rtl/user_proj_bram_wb.sv
// Wishbone slave RAM for the Caravel user area (mprjram window).
// Every hit waits DELAYS cycles, then the memory is accessed and a single
// cycle ack is returned. Dropping cyc/stb during the wait abandons the access.
module user_proj_bram_wb #(
    parameter logic [31:0] BASE_ADDR  = 32'h3800_0000,
    parameter int          ADDR_WIDTH = 10,
    parameter int          DELAYS     = 10
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    user_proj_bram_wb_if.slave   wbs,
    output logic [2:0]           irq
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    // Counter only needs to reach DELAYS-1 before the FSM leaves WAIT.
    localparam int CNT_W = (DELAYS > 1) ? $clog2(DELAYS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAYS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    // Request fields captured when the access is accepted.
    logic [ADDR_WIDTH-1:0]   idx_q;
    logic                    we_q;
    logic [3:0]              sel_q;
    logic [31:0]             wdat_q;

    logic [31:0]             rdat_q;
    logic [31:0]             mem [0:DEPTH-1];

    logic                    req_live;
    logic                    hit;
    logic                    latch_en;
    logic                    mem_go;
    logic                    mem_wr;
    logic                    unused_adr_lsb;

    // Byte offset within a word carries no meaning for this word memory.
    assign unused_adr_lsb = ^wbs.wbs_adr_i[1:0];

    assign req_live = wbs.wbs_cyc_i & wbs.wbs_stb_i;
    assign hit      = req_live &
                      (wbs.wbs_adr_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);

    // Next-state and access strobes; abort takes precedence over the final wait count.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        latch_en = 1'b0;
        mem_go   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (hit) begin
                    state_d  = S_WAIT;
                    cnt_d    = '0;
                    latch_en = 1'b1;
                end
            end
            S_WAIT: begin
                if (!req_live) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_ACK;
                    cnt_d   = '0;
                    mem_go  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Reset wins over a pending write on the same edge.
    assign mem_wr = mem_go & we_q & ~wb_rst_i;

    // State, wait counter and read-data register; read data is zero except in ACK.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdat_q  <= (mem_go && !we_q) ? mem[idx_q] : '0;
        end
    end

    // Capture the request so master changes during the wait are ignored.
    always_ff @(posedge wb_clk_i) begin
        if (latch_en) begin
            idx_q  <= wbs.wbs_adr_i[ADDR_WIDTH+1:2];
            we_q   <= wbs.wbs_we_i;
            sel_q  <= wbs.wbs_sel_i;
            wdat_q <= wbs.wbs_dat_i;
        end
    end

    // Byte-lane write into the array; contents survive reset.
    always_ff @(posedge wb_clk_i) begin
        if (mem_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (sel_q[b]) begin
                    mem[idx_q][8*b +: 8] <= wdat_q[8*b +: 8];
                end
            end
        end
    end

    assign wbs.wbs_ack_o = (state_q == S_ACK);
    assign wbs.wbs_dat_o = rdat_q;
    assign irq           = 3'b000;

endmodule

// File: tb/tb_user_proj_bram_wb.sv
// Randomised bench for user_proj_bram_wb with a transaction-level memory model.
module tb_user_proj_bram_wb;

    localparam int          DELAYS = 10;
    localparam int          AW     = 10;
    localparam logic [31:0] BASE   = 32'h3800_0000;

    logic clk = 1'b0;
    logic rst;
    logic [2:0] irq;

    always #5 clk = ~clk;

    user_proj_bram_wb_if bus ();

    user_proj_bram_wb #(
        .BASE_ADDR (BASE),
        .ADDR_WIDTH(AW),
        .DELAYS    (DELAYS)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .wbs     (bus.slave),
        .irq     (irq)
    );

    // Behavioural memory: value plus which bytes have ever been written.
    logic [31:0] mem_m   [0:(1<<AW)-1];
    logic [3:0]  known_m [0:(1<<AW)-1];

    // Per-cycle expectations published by the driver.
    logic        chk_en;
    logic        exp_ack;
    logic [31:0] exp_dat;
    logic        exp_dat_chk;
    int          cur_cyc;

    int          last_ack_cyc;
    logic [31:0] last_rd;

    int vectors;
    int miscompares;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (txn cycle %0d, t=%0t)", name, act, exp, cur_cyc, $time);
        end
    endtask

    // Compare DUT outputs against the model on every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("ack", {31'b0, bus.wbs_ack_o}, {31'b0, exp_ack});
            if (exp_dat_chk) check("dat_o", bus.wbs_dat_o, exp_dat);
            check("irq", {29'b0, irq}, 32'h0);
            if (bus.wbs_ack_o === 1'b1) begin
                last_ack_cyc = cur_cyc;
                last_rd      = bus.wbs_dat_o;
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            rst           = 1'b0;
            bus.wbs_cyc_i = 1'b0;
            bus.wbs_stb_i = 1'b0;
            cur_cyc       = -1;
            exp_ack       = 1'b0;
            exp_dat       = 32'h0;
            exp_dat_chk   = 1'b1;
        end
    endtask

    // mode 0: hold until ack (or miss_hold cycles on a miss)
    // mode 1: drop cyc/stb in cycle 'at'
    // mode 2: pulse reset in cycle 'at' with the request still up, then drop it
    task automatic txn(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input int mode, input int at, input int miss_hold);
        bit hit;
        int idx;
        int ncyc;
        bit active;
        bit ack_expected;
        hit  = ((adr >> (AW + 2)) == (BASE >> (AW + 2)));
        idx  = int'((adr >> 2) % (1 << AW));
        ncyc = hit ? DELAYS + 2 : miss_hold;
        ack_expected = hit && (mode == 0);
        last_ack_cyc = -1;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #1;
            cur_cyc = c;
            active  = (mode == 0) || (c < at) || (mode == 2 && c == at);
            rst     = (mode == 2 && c == at);
            bus.wbs_cyc_i = active;
            bus.wbs_stb_i = active;
            bus.wbs_we_i  = we;
            bus.wbs_sel_i = sel;
            // Scribble on address/data mid-wait: must be ignored.
            bus.wbs_adr_i = (c == 0) ? adr : (adr ^ 32'h0000_0ffc);
            bus.wbs_dat_i = (c == 0) ? dat : ~dat;
            exp_ack     = ack_expected && (c == DELAYS + 1);
            exp_dat     = 32'h0;
            exp_dat_chk = 1'b1;
            if (exp_ack && !we) begin
                exp_dat     = mem_m[idx];
                exp_dat_chk = (known_m[idx] == 4'hF);
            end
            if (exp_ack && we) begin
                for (int b = 0; b < 4; b++) begin
                    if (sel[b]) begin
                        mem_m[idx][8*b +: 8] = dat[8*b +: 8];
                        known_m[idx][b]      = 1'b1;
                    end
                end
            end
        end
        @(negedge clk); #1;
        if (ack_expected) check("ack_cycle", 32'(last_ack_cyc), 32'(DELAYS + 1));
        else              check("no_ack", 32'(last_ack_cyc), 32'hFFFF_FFFF);
    endtask

    logic [31:0] radr;
    logic [31:0] rdat;
    int          rsel;

    initial begin
        vectors      = 0;
        miscompares  = 0;
        chk_en       = 1'b0;
        exp_ack      = 1'b0;
        exp_dat      = 32'h0;
        exp_dat_chk  = 1'b1;
        cur_cyc      = -1;
        last_ack_cyc = -1;
        last_rd      = 32'h0;
        for (int i = 0; i < (1 << AW); i++) begin
            known_m[i] = 4'h0;
            mem_m[i]   = 32'h0;
        end

        // Reset held with a live write request on the bus.
        rst           = 1'b1;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = 1'b1;
        bus.wbs_sel_i = 4'hF;
        bus.wbs_adr_i = BASE;
        bus.wbs_dat_i = 32'hCAFE_F00D;
        repeat (3) begin
            @(posedge clk); #1;
            chk_en = 1'b1;
        end
        txn(1'b1, BASE, 32'hCAFE_F00D, 4'hF, 0, 0, 0);
        check("lat_after_reset", 32'(last_ack_cyc), 32'd11);
        idle(2);

        // Full-word write / read.
        txn(1'b1, 32'h3800_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
        check("lat_write", 32'(last_ack_cyc), 32'd11);
        idle(1);
        txn(1'b0, 32'h3800_0010, 32'h0, 4'hF, 0, 0, 0);
        check("lat_read", 32'(last_ack_cyc), 32'd11);
        check("rd_deadbeef", last_rd, 32'hDEAD_BEEF);

        // Byte enables.
        txn(1'b1, 32'h3800_0040, 32'h1122_3344, 4'hF, 0, 0, 0);
        txn(1'b1, 32'h3800_0040, 32'hAABB_CCDD, 4'b0010, 0, 0, 0);
        txn(1'b0, 32'h3800_0040, 32'h0, 4'hF, 0, 0, 0);
        check("rd_bytelane", last_rd, 32'h1122_CC44);

        // Decode misses, then the base word is unchanged.
        idle(1);
        txn(1'b0, 32'h3000_0000, 32'h0, 4'hF, 0, 0, 30);
        txn(1'b1, 32'h3800_1000, 32'h0123_4567, 4'hF, 0, 0, 30);
        idle(1);
        txn(1'b0, BASE, 32'h0, 4'hF, 0, 0, 0);
        check("rd_after_miss", last_rd, 32'hCAFE_F00D);

        // Aborts by strobe drop and by reset.
        txn(1'b1, 32'h3800_0020, 32'h0BAD_C0DE, 4'hF, 0, 0, 0);
        idle(1);
        txn(1'b1, 32'h3800_0020, 32'h5555_5555, 4'hF, 1, 5, 0);
        txn(1'b0, 32'h3800_0020, 32'h0, 4'hF, 0, 0, 0);
        check("rd_after_drop", last_rd, 32'h0BAD_C0DE);
        txn(1'b1, 32'h3800_0020, 32'h5555_5555, 4'hF, 2, 5, 0);
        txn(1'b0, 32'h3800_0020, 32'h0, 4'hF, 0, 0, 0);
        check("rd_after_rst", last_rd, 32'h0BAD_C0DE);

        // sel = 0 write completes but changes nothing.
        txn(1'b1, 32'h3800_0010, 32'h0000_0000, 4'h0, 0, 0, 0);
        txn(1'b0, 32'h3800_0010, 32'h0, 4'hF, 0, 0, 0);
        check("rd_after_sel0", last_rd, 32'hDEAD_BEEF);

        // Preload a small working set so every random read is defined.
        for (int i = 0; i < 16; i++) begin
            txn(1'b1, BASE + 32'(i * 4), $urandom, 4'hF, 0, 0, 0);
        end

        // Randomised traffic.
        for (int n = 0; n < 150; n++) begin
            int r;
            r    = $urandom_range(0, 9);
            radr = BASE | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            rdat = $urandom;
            rsel = $urandom_range(0, 15);
            case (r)
                0, 1, 2: txn(1'b1, radr, rdat, 4'(rsel), 0, 0, 0);
                3, 4, 5: txn(1'b0, radr, rdat, 4'(rsel), 0, 0, 0);
                6: begin
                    case ($urandom_range(0, 2))
                        0:       radr = 32'h3000_0000 | ($urandom & 32'h0000_fffc);
                        1:       radr = BASE + 32'h1000 + (32'($urandom_range(0, 1023)) << 2);
                        default: radr = BASE - 32'd4;
                    endcase
                    txn(1'($urandom_range(0, 1)), radr, rdat, 4'(rsel), 0, 0, $urandom_range(1, 15));
                end
                7: txn(1'($urandom_range(0, 1)), radr, rdat, 4'(rsel), 1, $urandom_range(1, DELAYS), 0);
                default: txn(1'($urandom_range(0, 1)), radr, rdat, 4'(rsel), 2, $urandom_range(1, DELAYS), 0);
            endcase
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
